updown_counter_param: RTL and testbench

Parametrised up/down modulo counter, the successor to the fixed 3-bit counter. It adds a programmable width and modulus, a variable step, enable and synchronous load. It also produces a terminal-count flag and a registered wrap pulse. Used as the generic counting primitive for timers, address sequencers and divider chains in the practice designs.

---
 rtl/updown_counter_param_if.sv | 25 ++
 rtl/updown_counter_param.sv | 87 ++++++++
 tb/tb_updown_counter_param.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_param_if.sv
// Control/data bundle for the parametrised up/down counter.
// The master drives the count controls; the slave (the counter) drives the results.
interface updown_counter_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 3
);
  logic              i_en;
  logic              i_mode;
  logic              i_load;
  logic [WIDTH-1:0]  i_din;
  logic [STEP_W-1:0] i_step;
  logic [WIDTH-1:0]  o_dout;
  logic              o_wrap;
  logic              o_tc;

  modport master (
    output i_en, i_mode, i_load, i_din, i_step,
    input  o_dout, o_wrap, o_tc
  );

  modport slave (
    input  i_en, i_mode, i_load, i_din, i_step,
    output o_dout, o_wrap, o_tc
  );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down modulo counter with variable step, load, terminal count and wrap pulse.
// Define UPDOWN_COUNTER_SAT_EN to clamp at 0/MAX_VAL instead of wrapping (wrap becomes a clip flag).
module updown_counter_param #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter int STEP_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  updown_counter_param_if.slave bus
);

  if (MAX_VAL < 1 || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_max_val
    $fatal(1, "updown_counter_param: MAX_VAL out of range 1..2**WIDTH-1");
  end
  if ((1 << STEP_W) - 1 > MAX_VAL + 1) begin : g_bad_step_w
    $fatal(1, "updown_counter_param: largest step exceeds the modulus");
  end

  localparam logic [WIDTH-1:0] MAX_DOUT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VAL);
`ifndef UPDOWN_COUNTER_SAT_EN
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MAX_VAL + 1);
`endif

  logic [WIDTH-1:0] r_dout;
  logic             r_wrap;

  logic [WIDTH:0]   w_dout_ext;
  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_next_dout;
  logic             w_next_wrap;

  // One extra bit keeps dout+step exact so the overflow compare is unsigned-safe.
  assign w_dout_ext = {1'b0, r_dout};
  assign w_step_ext = (WIDTH+1)'(bus.i_step);
  assign w_sum      = w_dout_ext + w_step_ext;

  always_comb begin
    w_next_dout = r_dout;
    w_next_wrap = 1'b0;
    if (bus.i_load) begin
      w_next_dout = (bus.i_din > MAX_DOUT) ? MAX_DOUT : bus.i_din;
    end else if (bus.i_en) begin
      if (!bus.i_mode) begin
        if (w_sum > MAX_EXT) begin
`ifdef UPDOWN_COUNTER_SAT_EN
          w_next_dout = MAX_DOUT;
`else
          w_next_dout = WIDTH'(w_sum - MOD_EXT);
`endif
          w_next_wrap = 1'b1;
        end else begin
          w_next_dout = WIDTH'(w_sum);
        end
      end else begin
        if (w_step_ext > w_dout_ext) begin
`ifdef UPDOWN_COUNTER_SAT_EN
          w_next_dout = '0;
`else
          w_next_dout = WIDTH'(w_dout_ext + MOD_EXT - w_step_ext);
`endif
          w_next_wrap = 1'b1;
        end else begin
          w_next_dout = WIDTH'(w_dout_ext - w_step_ext);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_dout <= w_next_dout;
      r_wrap <= w_next_wrap;
    end
  end

  assign bus.o_dout = r_dout;
  assign bus.o_wrap = r_wrap;
  // tc tracks mode combinationally so a direction flip is visible without a clock.
  assign bus.o_tc   = bus.i_mode ? (r_dout == '0) : (r_dout == MAX_DOUT);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param (WIDTH=4, MAX_VAL=9, STEP_W=2) with a per-cycle reference model.
// Build with or without UPDOWN_COUNTER_SAT_EN; expectations follow the same macro.
module tb_updown_counter_param;
  localparam int WIDTH   = 4;
  localparam int MAX_VAL = 9;
  localparam int STEP_W  = 2;
  localparam int MOD     = MAX_VAL + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  int   m_dout = 0;
  int   m_wrap = 0;

  updown_counter_param_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_if ();

  updown_counter_param #(
    .WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .STEP_W(STEP_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the count range.
  always @(posedge clk or negedge rst) begin
    int n;
    if (!rst) begin
      m_dout = 0;
      m_wrap = 0;
    end else if (u_if.i_load) begin
      m_dout = (int'(u_if.i_din) > MAX_VAL) ? MAX_VAL : int'(u_if.i_din);
      m_wrap = 0;
    end else if (u_if.i_en) begin
      n = u_if.i_mode ? m_dout - int'(u_if.i_step) : m_dout + int'(u_if.i_step);
      m_wrap = (n < 0 || n > MAX_VAL) ? 1 : 0;
`ifdef UPDOWN_COUNTER_SAT_EN
      m_dout = (n < 0) ? 0 : (n > MAX_VAL) ? MAX_VAL : n;
`else
      m_dout = (n + MOD) % MOD;
`endif
    end else begin
      m_wrap = 0;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("model_dout", int'(u_if.o_dout), m_dout);
      chk("model_wrap", int'(u_if.o_wrap), m_wrap);
      chk("model_tc", int'(u_if.o_tc),
          ((!u_if.i_mode && m_dout == MAX_VAL) || (u_if.i_mode && m_dout == 0)) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_dw(input string name, input int d, input int w);
    chk({name, "_dout"}, int'(u_if.o_dout), d);
    chk({name, "_wrap"}, int'(u_if.o_wrap), w);
  endtask

  task automatic do_load(input int v);
    u_if.i_load = 1'b1;
    u_if.i_din  = WIDTH'(v);
    tick();
    u_if.i_load = 1'b0;
  endtask

  initial begin
    int exp_d;
    u_if.i_en   = 1'b0;
    u_if.i_mode = 1'b0;
    u_if.i_load = 1'b0;
    u_if.i_din  = '0;
    u_if.i_step = '0;
    #1 rst = 1'b0;
    #11;
    expect_dw("reset", 0, 0);
    rst = 1'b1;

    // Up by one for ten cycles from reset.
    u_if.i_en = 1'b1; u_if.i_mode = 1'b0; u_if.i_step = 2'd1;
    for (int i = 1; i <= 10; i++) begin
      tick();
`ifdef UPDOWN_COUNTER_SAT_EN
      exp_d = (i == 10) ? 9 : i;
`else
      exp_d = i % 10;
`endif
      expect_dw("up1", exp_d, (i == 10) ? 1 : 0);
      chk("up1_tc", int'(u_if.o_tc), (exp_d == 9) ? 1 : 0);
    end

    // Count to 5, then asynchronous reset between edges.
    do_load(0);
    for (int i = 0; i < 5; i++) tick();
    expect_dw("to5", 5, 0);
    rst = 1'b0;
    #1;
    expect_dw("async_rst", 0, 0);
    rst = 1'b1;
    tick();
    expect_dw("post_rst", 1, 0);

    // Load 2, then count down by 3.
    do_load(2);
    expect_dw("load2", 2, 0);
    u_if.i_mode = 1'b1; u_if.i_step = 2'd3;
`ifdef UPDOWN_COUNTER_SAT_EN
    tick(); expect_dw("down3_a", 0, 1);
    chk("down3_tc", int'(u_if.o_tc), 1);
    tick(); expect_dw("down3_b", 0, 1);
`else
    tick(); expect_dw("down3_a", 9, 1);
    chk("down3_tc9", int'(u_if.o_tc), 0);
    tick(); expect_dw("down3_b", 6, 0);
    tick(); expect_dw("down3_c", 3, 0);
    tick(); expect_dw("down3_d", 0, 0);
    chk("down3_tc0", int'(u_if.o_tc), 1);
`endif

    // Load clamp and load priority over count.
    u_if.i_en = 1'b0;
    do_load(12);
    expect_dw("clamp", 9, 0);
    u_if.i_en = 1'b1; u_if.i_mode = 1'b0; u_if.i_step = 2'd3;
    tick();
`ifdef UPDOWN_COUNTER_SAT_EN
    expect_dw("up3_ovf", 9, 1);
`else
    expect_dw("up3_ovf", 2, 1);
`endif
    do_load(4);
    expect_dw("load_wins", 4, 0);

    // Hold, zero step, and combinational tc.
    u_if.i_en = 1'b0;
    do_load(7);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_dw("hold", 7, 0);
    end
    u_if.i_en = 1'b1; u_if.i_step = 2'd0;
    tick();
    expect_dw("step0", 7, 0);
    u_if.i_en = 1'b0;
    u_if.i_mode = 1'b0;
    do_load(0);
    #1 chk("tc_up_at0", int'(u_if.o_tc), 0);
    u_if.i_mode = 1'b1;
    #1 chk("tc_dn_at0", int'(u_if.o_tc), 1);
    do_load(9);
    #1 chk("tc_dn_at9", int'(u_if.o_tc), 0);
    u_if.i_mode = 1'b0;
    #1 chk("tc_up_at9", int'(u_if.o_tc), 1);

    // Boundary steps: clamp in saturating builds, wrap otherwise.
    do_load(8);
    u_if.i_en = 1'b1; u_if.i_mode = 1'b0; u_if.i_step = 2'd3;
    tick();
`ifdef UPDOWN_COUNTER_SAT_EN
    expect_dw("b_up3", 9, 1);
    u_if.i_step = 2'd1;
    tick(); expect_dw("b_up1", 9, 1);
`else
    expect_dw("b_up3", 1, 1);
    u_if.i_step = 2'd1;
    tick(); expect_dw("b_up1", 2, 0);
`endif
    do_load(1);
    u_if.i_mode = 1'b1; u_if.i_step = 2'd1;
    tick(); expect_dw("b_dn1", 0, 0);
    u_if.i_step = 2'd2;
    tick();
`ifdef UPDOWN_COUNTER_SAT_EN
    expect_dw("b_dn2", 0, 1);
`else
    expect_dw("b_dn2", 8, 1);
`endif

    tick();
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
